// File: rtl/pc_sequencer.sv
// Next-PC controller for the 5-stage MIPS pipeline: owns the fetch address and
// arbitrates boot, exception/eret, branch, stall and fetch-handshake redirects.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        fetch_ready,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        redirect,
  output logic        pend_valid,
  output logic        adel
);

  localparam int unsigned PC_W = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_redirect;
  logic            r_pend_valid;
  logic [PC_W-1:0] r_pend_target;

  state_t          w_state_nxt;
  logic [PC_W-1:0] w_pc_nxt;
  logic            w_redirect_nxt;
  logic            w_pend_valid_nxt;
  logic [PC_W-1:0] w_pend_target_nxt;
  logic            w_advance;

  assign w_advance = !stall && fetch_ready;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_redirect    <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_redirect    <= w_redirect_nxt;
      r_pend_valid  <= w_pend_valid_nxt;
      r_pend_target <= w_pend_target_nxt;
    end
  end

  // Next-state and redirect arbitration, highest priority first
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_redirect_nxt    = 1'b0;
    w_pend_valid_nxt  = r_pend_valid;
    w_pend_target_nxt = r_pend_target;
    case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end
      RUN, HOLD: begin
        if (req) begin
          w_pc_nxt         = HANDLER_PC;
          w_pend_valid_nxt = 1'b0;
          w_redirect_nxt   = 1'b1;
          w_state_nxt      = RUN;
        end else if (eret && !stall) begin
          w_pc_nxt         = epc;
          w_pend_valid_nxt = 1'b0;
          w_redirect_nxt   = 1'b1;
          w_state_nxt      = RUN;
        end else if (w_advance) begin
          w_state_nxt      = RUN;
          w_pend_valid_nxt = 1'b0;
          if (br_valid) begin
            w_pc_nxt = br_target;
          end else if (r_pend_valid) begin
            w_pc_nxt = r_pend_target;
          end else begin
            w_pc_nxt = r_pc + PC_W'(4);
          end
        end else begin
          // Fetch held: keep a taken branch so the one-cycle pulse is not lost
          w_state_nxt = HOLD;
          if (br_valid) begin
            w_pend_valid_nxt  = 1'b1;
            w_pend_target_nxt = br_target;
          end
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  assign pc         = r_pc;
  assign pc_valid   = (r_state != BOOT);
  assign redirect   = r_redirect;
  assign pend_valid = r_pend_valid;
  assign adel       = pc_valid &&
                      ((r_pc[1:0] != 2'b00) || (r_pc < TEXT_LO) || (r_pc > TEXT_HI));

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        fetch_ready;
  logic        br_valid;
  logic [31:0] br_target;
  logic        req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] pc;
  logic        pc_valid;
  logic        redirect;
  logic        pend_valid;
  logic        adel;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer dut (
    .clk         (clk),
    .reset       (rst_n),
    .stall       (stall),
    .fetch_ready (fetch_ready),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .req         (req),
    .eret        (eret),
    .epc         (epc),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .redirect    (redirect),
    .pend_valid  (pend_valid),
    .adel        (adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        fr;
    logic        bv;
    logic [31:0] bt;
    logic        req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] e_pc;
    logic        e_pv;
    logic        e_red;
    logic        e_pend;
    logic        e_adel;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic f, logic b, logic [31:0] t, logic r,
                              logic e, logic [31:0] ep, logic [31:0] xpc,
                              logic xpv, logic xred, logic xpend, logic xadel);
    vec_t v;
    v.stall = s;  v.fr = f;  v.bv = b;  v.bt = t;  v.req = r;  v.eret = e;  v.epc = ep;
    v.e_pc = xpc; v.e_pv = xpv; v.e_red = xred; v.e_pend = xpend; v.e_adel = xadel;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] xpc, input logic xpv,
                           input logic xred, input logic xpend, input logic xadel);
    chk({tag, ".pc"},         pc,                 xpc);
    chk({tag, ".pc_valid"},   32'(pc_valid),      32'(xpv));
    chk({tag, ".redirect"},   32'(redirect),      32'(xred));
    chk({tag, ".pend_valid"}, 32'(pend_valid),    32'(xpend));
    chk({tag, ".adel"},       32'(adel),          32'(xadel));
  endtask

  task automatic drive(input logic s, input logic f, input logic b, input logic [31:0] t,
                       input logic r, input logic e, input logic [31:0] ep);
    stall = s; fetch_ready = f; br_valid = b; br_target = t; req = r; eret = e; epc = ep;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    //            stall fr bv target        req eret epc            pc          pv red pend adel
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3000, 1, 0, 0, 0)); // BOOT->RUN
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3004, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3008, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_300C, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3010, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_3400, 0, 0, 32'h0,         32'h0000_3010, 1, 0, 1, 0)); // latch
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3010, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3010, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3400, 1, 0, 0, 0)); // replay
    vecs.push_back(mk(0, 1, 1, 32'h0000_3020, 0, 0, 32'h0,         32'h0000_3020, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         1, 0, 32'h0,         32'h0000_4180, 1, 1, 0, 0)); // req under stall
    vecs.push_back(mk(1, 1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_4180, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         0, 1, 32'h0000_3088, 32'h0000_4180, 1, 0, 0, 0)); // eret held
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 1, 32'h0000_3088, 32'h0000_3088, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_308C, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_5000, 0, 0, 32'h0,         32'h0000_308C, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h0000_3088, 32'h0000_4180, 1, 1, 0, 0)); // req beats eret
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_4184, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h0000_3002, 0, 0, 32'h0,         32'h0000_3002, 1, 0, 0, 1)); // misaligned
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3006, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 32'h0000_7000, 0, 0, 32'h0,         32'h0000_7000, 1, 0, 0, 1)); // above text
    vecs.push_back(mk(0, 1, 1, 32'h0000_6FFC, 0, 0, 32'h0,         32'h0000_6FFC, 1, 0, 0, 0)); // top legal
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_7000, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0000_3100, 0, 0, 32'h0,         32'h0000_7000, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0000_3200, 0, 0, 32'h0,         32'h0000_7000, 1, 0, 1, 1)); // overwrite
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3200, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_3300, 0, 0, 32'h0,         32'h0000_3200, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 32'h0000_3500, 0, 0, 32'h0,         32'h0000_3500, 1, 0, 0, 0)); // live br wins
    vecs.push_back(mk(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,         32'hFFFF_FFFC, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_0000, 1, 0, 0, 1)); // wrap
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h0000_3000, 32'h0000_3000, 1, 1, 0, 0)); // eret, !ready
    vecs.push_back(mk(0, 1, 1, 32'h0000_3400, 1, 0, 32'h0,         32'h0000_4180, 1, 1, 0, 0)); // req drops br
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_4184, 1, 0, 0, 0));

    #12;
    check_all("reset", 32'h0000_3000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("boot", 32'h0000_3000, 1'b0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].fr, vecs[i].bv, vecs[i].bt, vecs[i].req,
            vecs[i].eret, vecs[i].epc);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_pv, vecs[i].e_red,
                vecs[i].e_pend, vecs[i].e_adel);
    end

    // Reset mid-HOLD discards a pending target; BOOT ignores req
    drive(1'b0, 1'b0, 1'b1, 32'h0000_3600, 1'b0, 1'b0, 32'h0);
    step();
    check_all("hold_pend", 32'h0000_4184, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 32'h0000_3000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    check_all("boot_ign_req", 32'h0000_3000, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    check_all("post_rst_adv", 32'h0000_3004, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
